pixel_line_buf: RTL and testbench
=================================

PIXEL_LINE_BUF -- requirements
Module: pixel_line_buf

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 16, bit width of one pixel.
REQ-002 SHALL have parameter NUM_PIXEL, default 16, pixels per line.
REQ-003 SHALL have port CLK  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port PIXEL_VALID  input  1  upstream pixel strobe; no backpressure.
REQ-006 SHALL have port PIXEL_DATA  input  PIXEL_WIDTH  upstream pixel, sampled when PIXEL_VALID=1.
REQ-007 SHALL have port M_VALID  output  1  output pixel valid.
REQ-008 SHALL have port M_READY  input  1  downstream accept.
REQ-009 SHALL have port M_DATA  output  PIXEL_WIDTH  output pixel; all zeros when M_VALID=0.
REQ-010 SHALL have port M_SOL  output  1  high with M_VALID on the first pixel of a line.
REQ-011 SHALL have port M_EOL  output  1  high with M_VALID on the last pixel of a line.
REQ-012 SHALL have port LINE_CNT  output  16  lines fully delivered downstream, wraps 0xFFFF->0.
REQ-013 SHALL have port DROP_CNT  output  8  lines dropped on overflow, saturates at 0xFF.
REQ-014 SHALL have port OVERFLOW  output  1  sticky, set on first dropped line.

Function
REQ-015 SHALL hold two line banks of NUM_PIXEL entries each, with one full flag per bank.
REQ-016 Write FSM SHALL have states W_FILL and W_DROP, with write index wr_idx (0..NUM_PIXEL-1) and write bank wr_bank.
REQ-017 In W_FILL, PIXEL_VALID=1 with wr_idx=0 and bank wr_bank full SHALL enter W_DROP, discard the pixel, set OVERFLOW and increment DROP_CNT.
REQ-018 In W_FILL, otherwise, PIXEL_VALID=1 SHALL write PIXEL_DATA to bank[wr_bank][wr_idx] and increment wr_idx.
REQ-019 A W_FILL write at wr_idx=NUM_PIXEL-1 SHALL set full[wr_bank], toggle wr_bank and clear wr_idx.
REQ-020 In W_DROP, each PIXEL_VALID SHALL advance wr_idx without writing; on the pixel at NUM_PIXEL-1 it SHALL clear wr_idx and return to W_FILL with wr_bank unchanged.
REQ-021 PIXEL_VALID gaps mid-line SHALL pause the write side; a line completes only after NUM_PIXEL valid pixels.
REQ-022 Read FSM SHALL have states R_IDLE and R_SEND, with read index rd_idx and read bank rd_bank.
REQ-023 R_IDLE SHALL go to R_SEND on the cycle full[rd_bank]=1 is seen, so the first M_VALID is 1 cycle after the edge that sets full.
REQ-024 In R_SEND, M_VALID=1 and M_DATA=bank[rd_bank][rd_idx]; M_SOL=(rd_idx==0); M_EOL=(rd_idx==NUM_PIXEL-1).
REQ-025 M_DATA, M_SOL and M_EOL SHALL stay stable while M_VALID=1 and M_READY=0.
REQ-026 A transfer with M_VALID and M_READY both 1 SHALL increment rd_idx.
REQ-027 A transfer at rd_idx=NUM_PIXEL-1 SHALL clear full[rd_bank], toggle rd_bank, clear rd_idx and increment LINE_CNT.
REQ-028 After such a last-pixel transfer, the read side SHALL stay in R_SEND if the other bank is already full; otherwise it SHALL go to R_IDLE.
REQ-029 Write-side set of full on one bank and read-side clear on the other bank in the same cycle SHALL both take effect.
REQ-030 A freed bank SHALL be writable in the cycle after its flag clears; a line starting on that cycle SHALL NOT be dropped.
REQ-031 M_VALID, M_DATA, M_SOL and M_EOL SHALL be driven from registered state only, with no combinational path from PIXEL_* or M_READY.

Reset
REQ-032 RST=1 at a clock edge SHALL clear both full flags, wr_idx, rd_idx, wr_bank and rd_bank, set W_FILL and R_IDLE, and zero LINE_CNT, DROP_CNT and OVERFLOW.
REQ-033 After reset, M_VALID, M_SOL and M_EOL SHALL be 0 and M_DATA SHALL be 0.
REQ-034 Reset mid-line SHALL discard all partial and buffered lines; bank contents need not be cleared.

Structure
REQ-035 Package pixel_pkg SHALL hold PIXEL_WIDTH and NUM_PIXEL defaults and the write-state and read-state enums.
REQ-036 Storage SHALL be one sub-module, pixel_bank_ram: 2 x NUM_PIXEL x PIXEL_WIDTH, one write port, one asynchronous read port, no reset.

Verification
REQ-037 One line of 16 pixels 0x0001..0x0010 with M_READY=1 SHALL produce 0x0001..0x0010 starting 1 cycle after the last input, with SOL on 0x0001, EOL on 0x0010, and LINE_CNT=1.
REQ-038 Same line with M_READY toggling 1/0 each cycle SHALL hold data stable during stalls and deliver 16 transfers in order.
REQ-039 With M_READY=0, sending three lines A, B, C SHALL buffer A and B, drop C, and give OVERFLOW=1 and DROP_CNT=1; then setting M_READY=1 SHALL output A and then B, with LINE_CNT=2.
REQ-040 A line whose PIXEL_VALID has a 5-cycle gap after pixel 7 SHALL output all 16 pixels intact with no drop.
REQ-041 RST asserted after 8 pixels of a line, followed by a fresh full line, SHALL output only the fresh line, with LINE_CNT=1 and DROP_CNT=0.
REQ-042 With M_READY=1, back-to-back lines SHALL stream with both banks alternating and no drop, and LINE_CNT SHALL equal the number of lines sent.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared defaults, FSM state encodings and small helpers for the pixel line buffer.
package pixel_pkg;

  localparam int PIXEL_WIDTH_DEF = 16;
  localparam int NUM_PIXEL_DEF   = 16;

  typedef enum logic {
    W_FILL = 1'b0,
    W_DROP = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_SEND = 1'b1
  } rd_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pixel_bank_ram.sv
// Two line banks of pixels: one synchronous write port, one asynchronous read port, no reset.
module pixel_bank_ram #(
  parameter int PIXEL_WIDTH = 16,
  parameter int NUM_PIXEL   = 16,
  parameter int IDX_W       = 4
) (
  input  logic                   CLK,
  input  logic                   wr_en,
  input  logic                   wr_bank,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [PIXEL_WIDTH-1:0] wr_data,
  input  logic                   rd_bank,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [PIXEL_WIDTH-1:0] rd_data
);

  logic [PIXEL_WIDTH-1:0] mem [2][NUM_PIXEL];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_bank][wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_bank][rd_idx];

endmodule

// File: rtl/pixel_line_buf.sv
// Double-buffered pixel line buffer: a free-running pixel stream fills two line banks,
// complete lines are replayed downstream over a valid/ready interface.
module pixel_line_buf
  import pixel_pkg::*;
#(
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
  parameter int NUM_PIXEL   = NUM_PIXEL_DEF
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   PIXEL_VALID,
  input  logic [PIXEL_WIDTH-1:0] PIXEL_DATA,
  output logic                   M_VALID,
  input  logic                   M_READY,
  output logic [PIXEL_WIDTH-1:0] M_DATA,
  output logic                   M_SOL,
  output logic                   M_EOL,
  output logic [15:0]            LINE_CNT,
  output logic [7:0]             DROP_CNT,
  output logic                   OVERFLOW
);

  localparam int              IDX_W    = (NUM_PIXEL > 1) ? $clog2(NUM_PIXEL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXEL - 1);

  wr_state_e              wr_state, wr_state_nxt;
  logic [IDX_W-1:0]       wr_idx, wr_idx_nxt;
  logic                   wr_bank, wr_bank_nxt;
  logic                   ram_we, wr_set_full, wr_drop, bank_free;

  rd_state_e              rd_state, rd_state_nxt;
  logic [IDX_W-1:0]       rd_idx, rd_idx_nxt;
  logic                   rd_bank, rd_bank_nxt;
  logic                   rd_xfer, rd_last;

  logic [1:0]             full, full_nxt;
  logic [PIXEL_WIDTH-1:0] ram_rdata;
  logic [15:0]            line_cnt;
  logic [7:0]             drop_cnt;
  logic                   overflow;

  pixel_bank_ram #(
    .PIXEL_WIDTH(PIXEL_WIDTH),
    .NUM_PIXEL  (NUM_PIXEL),
    .IDX_W      (IDX_W)
  ) u_ram (
    .CLK    (CLK),
    .wr_en  (ram_we),
    .wr_bank(wr_bank),
    .wr_idx (wr_idx),
    .wr_data(PIXEL_DATA),
    .rd_bank(rd_bank),
    .rd_idx (rd_idx),
    .rd_data(ram_rdata)
  );

  // Handshake: a pixel moves downstream on a rising edge where M_VALID and M_READY are
  // both 1; while M_VALID=1 and M_READY=0 all output fields hold. Upstream has no ready.
  always_comb begin
    rd_state_nxt = rd_state;
    rd_idx_nxt   = rd_idx;
    rd_bank_nxt  = rd_bank;
    rd_xfer      = (rd_state == R_SEND) && M_READY;
    rd_last      = rd_xfer && (rd_idx == LAST_IDX);
    case (rd_state)
      R_IDLE: begin
        if (full[rd_bank]) rd_state_nxt = R_SEND;
      end
      R_SEND: begin
        if (rd_xfer) begin
          if (rd_idx == LAST_IDX) begin
            rd_idx_nxt   = '0;
            rd_bank_nxt  = ~rd_bank;
            rd_state_nxt = full[~rd_bank] ? R_SEND : R_IDLE;
          end else begin
            rd_idx_nxt = rd_idx + IDX_W'(1);
          end
        end
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  // A bank whose last pixel is leaving on this edge already counts as free, so a
  // line arriving exactly back-to-back with the drain is not dropped.
  assign bank_free = !full[wr_bank] || (rd_last && (rd_bank == wr_bank));

  always_comb begin
    wr_state_nxt = wr_state;
    wr_idx_nxt   = wr_idx;
    wr_bank_nxt  = wr_bank;
    ram_we       = 1'b0;
    wr_set_full  = 1'b0;
    wr_drop      = 1'b0;
    case (wr_state)
      W_FILL: begin
        if (PIXEL_VALID) begin
          if ((wr_idx == '0) && !bank_free) begin
            wr_drop      = 1'b1;
            wr_state_nxt = W_DROP;
            wr_idx_nxt   = wr_idx + IDX_W'(1);
          end else begin
            ram_we = 1'b1;
            if (wr_idx == LAST_IDX) begin
              wr_set_full = 1'b1;
              wr_bank_nxt = ~wr_bank;
              wr_idx_nxt  = '0;
            end else begin
              wr_idx_nxt = wr_idx + IDX_W'(1);
            end
          end
        end
      end
      W_DROP: begin
        if (PIXEL_VALID) begin
          if (wr_idx == LAST_IDX) begin
            wr_idx_nxt   = '0;
            wr_state_nxt = W_FILL;
          end else begin
            wr_idx_nxt = wr_idx + IDX_W'(1);
          end
        end
      end
      default: wr_state_nxt = W_FILL;
    endcase
  end

  always_comb begin
    full_nxt = full;
    if (rd_last)     full_nxt[rd_bank] = 1'b0;
    if (wr_set_full) full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_state <= W_FILL;
      wr_idx   <= '0;
      wr_bank  <= 1'b0;
      rd_state <= R_IDLE;
      rd_idx   <= '0;
      rd_bank  <= 1'b0;
      full     <= '0;
      line_cnt <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      wr_state <= wr_state_nxt;
      wr_idx   <= wr_idx_nxt;
      wr_bank  <= wr_bank_nxt;
      rd_state <= rd_state_nxt;
      rd_idx   <= rd_idx_nxt;
      rd_bank  <= rd_bank_nxt;
      full     <= full_nxt;
      if (rd_last) line_cnt <= line_cnt + 16'd1;
      if (wr_drop) begin
        drop_cnt <= sat_inc8(drop_cnt);
        overflow <= 1'b1;
      end
    end
  end

  assign M_VALID  = (rd_state == R_SEND);
  assign M_DATA   = M_VALID ? ram_rdata : '0;
  assign M_SOL    = M_VALID && (rd_idx == '0);
  assign M_EOL    = M_VALID && (rd_idx == LAST_IDX);
  assign LINE_CNT = line_cnt;
  assign DROP_CNT = drop_cnt;
  assign OVERFLOW = overflow;

endmodule

// File: tb/tb_pixel_line_buf.sv
// Directed bench for pixel_line_buf: linear stimulus, expected-output queue, immediate assertions.
module tb_pixel_line_buf;

  localparam int PW = 16;
  localparam int NP = 16;
  localparam int EW = PW + 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          PIXEL_VALID = 1'b0;
  logic [PW-1:0] PIXEL_DATA = '0;
  logic          M_VALID;
  logic          M_READY = 1'b0;
  logic [PW-1:0] M_DATA;
  logic          M_SOL;
  logic          M_EOL;
  logic [15:0]   LINE_CNT;
  logic [7:0]    DROP_CNT;
  logic          OVERFLOW;

  int vectors = 0;
  int miscompares = 0;

  logic [EW-1:0] exp_q[$];
  logic          prev_stall = 1'b0;
  logic [EW-1:0] held = '0;

  pixel_line_buf #(.PIXEL_WIDTH(PW), .NUM_PIXEL(NP)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PIXEL_VALID(PIXEL_VALID),
    .PIXEL_DATA (PIXEL_DATA),
    .M_VALID    (M_VALID),
    .M_READY    (M_READY),
    .M_DATA     (M_DATA),
    .M_SOL      (M_SOL),
    .M_EOL      (M_EOL),
    .LINE_CNT   (LINE_CNT),
    .DROP_CNT   (DROP_CNT),
    .OVERFLOW   (OVERFLOW)
  );

  // Clock and watchdog
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks (called aligned 1ns after a rising edge)
  task automatic send_pixels(input logic [PW-1:0] base, input int count, input int gap_after);
    for (int i = 0; i < count; i++) begin
      PIXEL_VALID = 1'b1;
      PIXEL_DATA  = base + PW'(i);
      @(posedge CLK); #1;
      if (i == gap_after) begin
        PIXEL_VALID = 1'b0;
        PIXEL_DATA  = '0;
        repeat (5) begin @(posedge CLK); #1; end
      end
    end
    PIXEL_VALID = 1'b0;
    PIXEL_DATA  = '0;
  endtask

  task automatic push_line(input logic [PW-1:0] base);
    for (int i = 0; i < NP; i++) begin
      exp_q.push_back({(i == 0), (i == NP - 1), base + PW'(i)});
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || M_VALID) && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check("drain_done", 32'(n < 500), 32'd1);
    @(posedge CLK); #1;
  endtask

  // Scoreboard: outputs sampled on the falling edge
  always @(negedge CLK) begin
    if (!RST) begin
      if (prev_stall) check("stall_hold", {M_VALID, M_SOL, M_EOL, M_DATA}, {1'b1, held});
      if (!M_VALID) check("idle_zero", {M_SOL, M_EOL, M_DATA}, '0);
      if (M_VALID && M_READY) begin
        if (exp_q.size() == 0) check("spurious_out", 32'(M_VALID), 32'd0);
        else check("out_pixel", {M_SOL, M_EOL, M_DATA}, exp_q.pop_front());
      end
      prev_stall = M_VALID && !M_READY;
      held       = {M_SOL, M_EOL, M_DATA};
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    // Reset
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_m_valid", 32'(M_VALID), 0);
    check("rst_m_data", 32'(M_DATA), 0);
    check("rst_sol_eol", 32'({M_SOL, M_EOL}), 0);
    check("rst_line_cnt", 32'(LINE_CNT), 0);
    check("rst_drop_cnt", 32'(DROP_CNT), 0);
    check("rst_overflow", 32'(OVERFLOW), 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    // Single line, ready always high, output latency
    M_READY = 1'b1;
    push_line(16'h0001);
    send_pixels(16'h0001, NP, -1);
    @(negedge CLK);
    check("lat_not_yet", 32'(M_VALID), 0);
    @(negedge CLK);
    check("lat_first_valid", 32'(M_VALID), 1);
    check("lat_first_data", 32'({M_SOL, M_DATA}), 32'h1_0001);
    wait_drain();
    check("line_cnt_1", 32'(LINE_CNT), 1);

    // Same line with ready toggling every cycle
    push_line(16'h0001);
    fork
      send_pixels(16'h0001, NP, -1);
      repeat (60) begin @(posedge CLK); #1; M_READY = ~M_READY; end
    join
    M_READY = 1'b1;
    wait_drain();
    check("line_cnt_2", 32'(LINE_CNT), 2);

    // Overflow: A, B buffered, C dropped while stalled
    M_READY = 1'b0;
    push_line(16'h0100);
    push_line(16'h0200);
    send_pixels(16'h0100, NP, -1);
    send_pixels(16'h0200, NP, -1);
    send_pixels(16'h0300, NP, -1);
    @(negedge CLK);
    check("ovf_flag", 32'(OVERFLOW), 1);
    check("ovf_drop_cnt", 32'(DROP_CNT), 1);
    check("ovf_line_cnt", 32'(LINE_CNT), 2);
    check("ovf_head", 32'({M_VALID, M_SOL, M_DATA}), 32'h3_0100);
    @(posedge CLK); #1;
    M_READY = 1'b1;
    wait_drain();
    check("ovf_line_cnt_after", 32'(LINE_CNT), 4);
    check("ovf_drop_cnt_after", 32'(DROP_CNT), 1);

    // Five-cycle input gap after pixel index 7
    push_line(16'h0400);
    send_pixels(16'h0400, NP, 7);
    wait_drain();
    check("gap_line_cnt", 32'(LINE_CNT), 5);
    check("gap_drop_cnt", 32'(DROP_CNT), 1);

    // Reset mid-line, then a fresh line
    send_pixels(16'h0500, 8, -1);
    RST = 1'b1;
    repeat (2) begin @(posedge CLK); #1; end
    RST = 1'b0;
    @(negedge CLK);
    check("mid_rst_valid", 32'(M_VALID), 0);
    check("mid_rst_cnts", 32'({LINE_CNT, DROP_CNT, 7'd0, OVERFLOW}), 0);
    @(posedge CLK); #1;
    push_line(16'h0600);
    send_pixels(16'h0600, NP, -1);
    wait_drain();
    check("mid_rst_line_cnt", 32'(LINE_CNT), 1);
    check("mid_rst_drop_cnt", 32'(DROP_CNT), 0);

    // Back-to-back lines streaming through both banks
    for (int l = 0; l < 4; l++) push_line(PW'(16'h1000 + 16'h0100 * l));
    for (int l = 0; l < 4; l++) send_pixels(PW'(16'h1000 + 16'h0100 * l), NP, -1);
    wait_drain();
    check("b2b_line_cnt", 32'(LINE_CNT), 5);
    check("b2b_drop_cnt", 32'(DROP_CNT), 0);
    check("b2b_overflow", 32'(OVERFLOW), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
